// File: rtl/prf_wb_arbiter.sv
// PRF writeback arbiter: per-bank round-robin over all writeback requestors, registered bank write ports.
// Optional macro PRF_WB_ZERO_PR_SQUASH_EN: PR 0 writes are acknowledged and dropped without using bank 0.
module prf_wb_arbiter #(
    parameter int XLEN               = 32,
    parameter int PR_COUNT           = 128,
    parameter int LOG_PR_COUNT       = $clog2(PR_COUNT),
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
    parameter int PRF_WR_COUNT       = 7
) (
    input  logic                                                         CLK,
    input  logic                                                         nRST,
    input  logic [PRF_WR_COUNT-1:0]                                      WB_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]                    WB_PR_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]                            WB_data_by_wr,
    output logic [PRF_WR_COUNT-1:0]                                      WB_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]                                    bank_WB_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] bank_WB_upper_PR_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                          bank_WB_data_by_bank
);
    localparam int WR_W = $clog2(PRF_WR_COUNT);

    logic [PRF_BANK_COUNT-1:0][WR_W-1:0]         ptr;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] req;
    logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] grant;
    logic [PRF_BANK_COUNT-1:0]                   win_vld;
    logic [PRF_BANK_COUNT-1:0][WR_W-1:0]         win_idx;
    logic [PRF_WR_COUNT-1:0]                     squash;

    always_comb begin
        squash = '0;
`ifdef PRF_WB_ZERO_PR_SQUASH_EN
        for (int i = 0; i < PRF_WR_COUNT; i++)
            squash[i] = WB_valid_by_wr[i] && (WB_PR_by_wr[i] == '0);
`endif
    end

    always_comb begin : arb
        int idx;
        idx     = 0;
        req     = '0;
        grant   = '0;
        win_vld = '0;
        win_idx = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int i = 0; i < PRF_WR_COUNT; i++)
                req[b][i] = WB_valid_by_wr[i] && !squash[i] &&
                            (WB_PR_by_wr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            // Scan starting at the pointer so the last winner drops to lowest priority.
            for (int k = 0; k < PRF_WR_COUNT; k++) begin
                idx = int'(ptr[b]) + k;
                if (idx >= PRF_WR_COUNT) idx = idx - PRF_WR_COUNT;
                if (!win_vld[b] && req[b][idx]) begin
                    win_vld[b]      = 1'b1;
                    win_idx[b]      = WR_W'(idx);
                    grant[b][idx]   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        WB_ready_by_wr = squash;
        for (int b = 0; b < PRF_BANK_COUNT; b++)
            WB_ready_by_wr = WB_ready_by_wr | grant[b];
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr                      <= '0;
            bank_WB_valid_by_bank    <= '0;
            bank_WB_upper_PR_by_bank <= '0;
            bank_WB_data_by_bank     <= '0;
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                bank_WB_valid_by_bank[b] <= win_vld[b];
                if (win_vld[b]) begin
                    bank_WB_upper_PR_by_bank[b] <=
                        WB_PR_by_wr[win_idx[b]][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                    bank_WB_data_by_bank[b] <= WB_data_by_wr[win_idx[b]];
                    ptr[b] <= (win_idx[b] == WR_W'(PRF_WR_COUNT-1)) ? '0 : win_idx[b] + WR_W'(1);
                end
            end
        end
    end
endmodule
